hilo_unit: RTL and testbench
============================

# hilo_unit

Sequencing and architectural-state block directly downstream of the shift-and-add multiplier. It starts a multiply when a MULT/MULTU reaches Execute, stalls the pipeline until the multiplier signals completion, and captures the 64-bit product into the HI/LO registers. It also services MTHI/MTLO writes and MFHI/MFLO reads, and clears the multiplier between operations.

## Interface
- `TIMEOUT`, default 40: maximum number of RUN cycles before an abort (compiled in only with the watchdog).
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `MultE` in 1: MULT/MULTU is in Execute.
- `MultSgn` in 1: signed multiply; passed through to the multiplier.
- `MulCompleted` in 1: multiplier `completed` flag.
- `MulHi`, `MulLo` in 32: multiplier `hi`/`lo` outputs.
- `MthiE`, `MtloE` in 1: MTHI/MTLO is in Execute.
- `MfhiE`, `MfloE` in 1: MFHI/MFLO is in Execute.
- `SrcAE` in 32: write data for MTHI/MTLO.
- `MulStartE` out 1: drives the multiplier `MultE`.
- `MulSgnE` out 1: drives the multiplier `MultSgn`.
- `MulRst` out 1: active-high clear to the multiplier `rst`.
- `StallMul` out 1: holds Fetch, Decode and Execute.
- `HiLoOutE` out 32: MFHI/MFLO read data.
- `hi`, `lo` out 32: architectural HI/LO registers.
- `TimeoutErr` out 1: sticky watchdog error flag.

Clock is `clk`. Reset is `rst_n`, asynchronous and active-low.

## Operation
- States: IDLE, RUN, WB, ABORT (2-bit encoding).
- **IDLE**
  - With `MultE`=1: `MulStartE`=1 and `StallMul`=1. The next state is RUN and the watchdog counter clears to 0.
  - Otherwise: `MthiE`/`MtloE` write `SrcAE` into `hi`/`lo` at the clock edge.
- **RUN**
  - `MulStartE`=1, `StallMul`=1, and the counter increments each cycle.
  - `MulCompleted`=1: `hi`<=`MulHi` and `lo`<=`MulLo` at that edge, then WB.
- **WB** (one cycle)
  - `StallMul`=0 and `MulRst`=1; the next state is IDLE.
  - `MultE` is ignored here, because it is still the same instruction leaving Execute.
- **ABORT** (one cycle)
  - Same outputs as WB, except `hi`/`lo` are left unchanged.
  - `TimeoutErr` is set to 1 and holds until reset.
- **Priority**
  - In IDLE, `MultE` beats `MthiE`/`MtloE`: a write in that same cycle is dropped.
  - If `MthiE` and `MtloE` are both 1, both registers are written with `SrcAE`.
- **Reads**
  - `HiLoOutE` = `hi` if `MfhiE`, else `lo` if `MfloE`, else 0. It is combinational from the registers and is valid in every state.
- `MulSgnE` is a combinational pass-through of `MultSgn`; a stalled Execute stage holds it stable.

## Timing
- **During reset** (`rst_n`=0):
  - State = IDLE; `hi`=`lo`=0; counter=0; `TimeoutErr`=0.
  - `MulStartE`=0, `StallMul`=0, `MulRst`=1, `HiLoOutE`=0.
- **Reset mid-RUN:** the same values apply immediately. The multiplier is cleared through `MulRst`, and no partial product is written.
- **Multiply sequence:**
  - Cycle 0 (IDLE, `MultE`=1): `StallMul` is 1 combinationally.
  - RUN lasts until `MulCompleted` is sampled high. `StallMul` stays high through that cycle.
  - Total stall = 1 + RUN cycles. With a multiplier that completes 33 cycles after start, `StallMul` is high for 34 cycles.
- The new `hi`/`lo` values are visible from the first cycle of WB. An MFHI issued right after the multiply reads the new value with no forwarding.
- A `MulCompleted` seen in IDLE, WB or ABORT is ignored.
- An MTHI/MTLO write lands at the edge of its own Execute cycle; an MFHI/MFLO on the next cycle sees it.

## Configuration
- `HILO_TIMEOUT_EN` defined:
  - A counter with width $clog2(TIMEOUT+1) runs in RUN.
  - When the counter equals `TIMEOUT` and `MulCompleted`=0, the next state is ABORT.
- `HILO_TIMEOUT_EN` undefined:
  - No counter is built and RUN waits indefinitely.
  - `TimeoutErr` is tied to 0 and ABORT is unreachable.

## Test plan
- **Reset:** assert `rst_n`=0 mid-RUN -> `hi`=`lo`=0, `StallMul`=0, `MulRst`=1 in that same cycle.
- **Unsigned multiply:** MULTU 0x0000FFFF×0x00010001 with the real multiplier -> `StallMul` high 34 cycles, then `hi`=0x00000000, `lo`=0xFFFFFFFF in WB, `MulRst`=1 for exactly one cycle.
- **Signed multiply:** MULT 7×6 -> `lo`=42, `hi`=0. Then MFLO in the next Execute cycle -> `HiLoOutE`=42.
- **Move-to/from:** MTHI 0xDEADBEEF, then MFHI the next cycle -> `HiLoOutE`=0xDEADBEEF, `lo` unchanged.
- **Priority:** `MultE`=1 and `MthiE`=1 together in IDLE -> the MTHI is dropped and `hi` ends up equal to the product high word.
- **Watchdog** (`HILO_TIMEOUT_EN`, `TIMEOUT`=40, `MulCompleted` held 0):
  - -> ABORT after 41 RUN cycles; `TimeoutErr`=1; `hi`/`lo` unchanged; `StallMul` drops.
  - With the macro undefined -> the bench still stalls at cycle 100.

Source files
------------

// File: rtl/hilo_unit_if.sv
// ============================================================================
// hilo_unit_if : pipeline and multiplier signals of the HI/LO sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

interface hilo_unit_if;
  logic        MultE;
  logic        MultSgn;
  logic        MulCompleted;
  logic [31:0] MulHi;
  logic [31:0] MulLo;
  logic        MthiE;
  logic        MtloE;
  logic        MfhiE;
  logic        MfloE;
  logic [31:0] SrcAE;
  logic        MulStartE;
  logic        MulSgnE;
  logic        MulRst;
  logic        StallMul;
  logic [31:0] HiLoOutE;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        TimeoutErr;

  modport slave (
    input  MultE, MultSgn, MulCompleted, MulHi, MulLo,
    input  MthiE, MtloE, MfhiE, MfloE, SrcAE,
    output MulStartE, MulSgnE, MulRst, StallMul, HiLoOutE, hi, lo, TimeoutErr
  );

  modport master (
    output MultE, MultSgn, MulCompleted, MulHi, MulLo,
    output MthiE, MtloE, MfhiE, MfloE, SrcAE,
    input  MulStartE, MulSgnE, MulRst, StallMul, HiLoOutE, hi, lo, TimeoutErr
  );
endinterface

`default_nettype wire

// File: rtl/hilo_unit.sv
// ============================================================================
// hilo_unit : multiply sequencing, pipeline stall and HI/LO register file.
// Optional RUN watchdog enabled by defining HILO_TIMEOUT_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module hilo_unit
`ifdef HILO_TIMEOUT_EN
#(
  parameter int TIMEOUT = 40
)
`endif
(
  input  logic       clk,
  input  logic       rst_n,
  hilo_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    WB    = 2'd2,
    ABORT = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        start_req;
  logic        expired;
  logic        timeout_err;

  assign start_req = (state == IDLE) && bus.MultE;

`ifdef HILO_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  assign expired = (cnt == CW'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (start_req) begin
        cnt <= '0;
      end else if (state == RUN) begin
        cnt <= cnt + 1'b1;
      end
      // Flag latches on the edge into ABORT and stays until reset
      if ((state == RUN) && !bus.MulCompleted && expired) begin
        timeout_err <= 1'b1;
      end
    end
  end
`else
  assign expired     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.MultE) begin
            state <= RUN;
          end else begin
            if (bus.MthiE) hi_q <= bus.SrcAE;
            if (bus.MtloE) lo_q <= bus.SrcAE;
          end
        end
        RUN: begin
          if (bus.MulCompleted) begin
            hi_q  <= bus.MulHi;
            lo_q  <= bus.MulLo;
            state <= WB;
          end else if (expired) begin
            state <= ABORT;
          end
        end
        // MultE is still the finished instruction leaving Execute here
        WB:      state <= IDLE;
        ABORT:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Start/stall must rise in the same cycle MultE arrives, so they stay combinational
  assign bus.MulStartE  = rst_n && (start_req || (state == RUN));
  assign bus.StallMul   = rst_n && (start_req || (state == RUN));
  assign bus.MulRst     = !rst_n || (state == WB) || (state == ABORT);
  assign bus.MulSgnE    = bus.MultSgn;
  assign bus.HiLoOutE   = bus.MfhiE ? hi_q : (bus.MfloE ? lo_q : 32'd0);
  assign bus.hi         = hi_q;
  assign bus.lo         = lo_q;
  assign bus.TimeoutErr = timeout_err;

endmodule

`default_nettype wire

// File: tb/tb_hilo_unit.sv
// ============================================================================
// tb_hilo_unit : scoreboard bench for hilo_unit with a 33-cycle multiplier model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_hilo_unit;

  logic clk;
  logic rst_n;

  hilo_unit_if bus ();

`ifdef HILO_TIMEOUT_EN
  hilo_unit #(.TIMEOUT(40)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
`else
  hilo_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier model: completes 33 cycles after start
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        hang;
  logic        force_comp;
  logic [5:0]  mcnt;
  logic [63:0] prod;

  always @(posedge clk) begin
    if (bus.MulRst) mcnt <= 6'd0;
    else if (bus.MulStartE) mcnt <= mcnt + 6'd1;
  end

  assign prod = bus.MulSgnE
              ? 64'($signed({{32{op_a[31]}}, op_a}) * $signed({{32{op_b[31]}}, op_b}))
              : ({32'd0, op_a} * {32'd0, op_b});
  assign bus.MulCompleted = force_comp || ((mcnt == 6'd33) && !hang);
  assign bus.MulHi        = prod[63:32];
  assign bus.MulLo        = prod[31:0];

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          stalls;
    logic        err;
  } mul_exp_t;

  mul_exp_t    mul_q[$];
  logic [31:0] rd_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT finishes a multiply or serves a read
  int       stall_cnt = 0;
  bit       prev_end  = 0;
  mul_exp_t e;
  logic [31:0] re;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_cnt = 0;
      prev_end  = 0;
    end else begin
      if (prev_end) begin
        chk("mulrst_one_cycle", {63'd0, bus.MulRst}, 64'd0);
        prev_end = 0;
      end
      if (bus.StallMul) stall_cnt++;
      if (bus.MulRst) begin
        if (mul_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_mul_end: got end-of-multiply expected none");
        end else begin
          e = mul_q.pop_front();
          chk("wb_hi", {32'd0, bus.hi}, {32'd0, e.hi});
          chk("wb_lo", {32'd0, bus.lo}, {32'd0, e.lo});
          chk("stall_cycles", 64'(stall_cnt), 64'(e.stalls));
          chk("wb_stall_low", {63'd0, bus.StallMul}, 64'd0);
          chk("wb_timeout_err", {63'd0, bus.TimeoutErr}, {63'd0, e.err});
        end
        stall_cnt = 0;
        prev_end  = 1;
      end
      if (bus.MfhiE || bus.MfloE) begin
        if (rd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_read: got read with value %h expected none", bus.HiLoOutE);
        end else begin
          re = rd_q.pop_front();
          chk("read_data", {32'd0, bus.HiLoOutE}, {32'd0, re});
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mfhi(input logic [31:0] exp);
    rd_q.push_back(exp);
    bus.MfhiE = 1'b1;
    cyc();
    bus.MfhiE = 1'b0;
  endtask

  task automatic mflo(input logic [31:0] exp);
    rd_q.push_back(exp);
    bus.MfloE = 1'b1;
    cyc();
    bus.MfloE = 1'b0;
  endtask

  task automatic mt(input bit h, input bit l, input logic [31:0] d);
    bus.MthiE = h;
    bus.MtloE = l;
    bus.SrcAE = d;
    cyc();
    bus.MthiE = 1'b0;
    bus.MtloE = 1'b0;
  endtask

  // Runs a multiply until Execute is released; MultE stays up through WB/ABORT
  task automatic mult(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                      input bit with_mthi, input mul_exp_t x);
    bit done;
    done = 0;
    mul_q.push_back(x);
    op_a        = a;
    op_b        = b;
    bus.MultSgn = sgn;
    bus.MultE   = 1'b1;
    if (with_mthi) begin
      bus.MthiE = 1'b1;
      bus.SrcAE = 32'h1111_1111;
    end
    #1;
    chk("stall_cycle0", {63'd0, bus.StallMul}, 64'd1);
    chk("mulsgn_pass", {63'd0, bus.MulSgnE}, {63'd0, sgn});
    for (int i = 0; i < 200; i++) begin
      cyc();
      bus.MthiE = 1'b0;
      if (!bus.StallMul) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL mult_release: got StallMul stuck expected release within 200 cycles");
    end
    cyc();
    bus.MultE = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n          = 1'b0;
    bus.MultE      = 1'b1;
    bus.MultSgn    = 1'b0;
    bus.MthiE      = 1'b0;
    bus.MtloE      = 1'b0;
    bus.MfhiE      = 1'b0;
    bus.MfloE      = 1'b0;
    bus.SrcAE      = 32'd0;
    op_a           = 32'd0;
    op_b           = 32'd0;
    hang           = 1'b0;
    force_comp     = 1'b0;

    #12;
    chk("rst_stall", {63'd0, bus.StallMul}, 64'd0);
    chk("rst_start", {63'd0, bus.MulStartE}, 64'd0);
    chk("rst_mulrst", {63'd0, bus.MulRst}, 64'd1);
    chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("rst_err", {63'd0, bus.TimeoutErr}, 64'd0);
    bus.MultE = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("idle_mulrst", {63'd0, bus.MulRst}, 64'd0);

    mult(32'h0000_FFFF, 32'h0001_0001, 1'b0, 1'b0, '{32'h0000_0000, 32'hFFFF_FFFF, 34, 1'b0});
    mult(32'd7, 32'd6, 1'b1, 1'b0, '{32'd0, 32'd42, 34, 1'b0});
    mflo(32'd42);
    mult(32'hFFFF_FFFD, 32'd5, 1'b1, 1'b0, '{32'hFFFF_FFFF, 32'hFFFF_FFF1, 34, 1'b0});
    mfhi(32'hFFFF_FFFF);

    mt(1'b1, 1'b0, 32'hDEAD_BEEF);
    mfhi(32'hDEAD_BEEF);
    mflo(32'hFFFF_FFF1);
    mt(1'b1, 1'b1, 32'hA5A5_A5A5);
    mfhi(32'hA5A5_A5A5);
    mflo(32'hA5A5_A5A5);

    mult(32'h8000_0000, 32'd4, 1'b0, 1'b1, '{32'h0000_0002, 32'h0000_0000, 34, 1'b0});
    mfhi(32'h0000_0002);

    op_a       = 32'h1234_5678;
    op_b       = 32'd9;
    force_comp = 1'b1;
    cyc();
    force_comp = 1'b0;
    mfhi(32'h0000_0002);
    mflo(32'h0000_0000);

    hang = 1'b1;
`ifdef HILO_TIMEOUT_EN
    mult(32'd3, 32'd3, 1'b0, 1'b0, '{32'h0000_0002, 32'h0000_0000, 42, 1'b1});
    chk("err_sticky", {63'd0, bus.TimeoutErr}, 64'd1);
    mfhi(32'h0000_0002);
    bus.MultE = 1'b1;
    repeat (5) cyc();
`else
    bus.MultE = 1'b1;
    repeat (100) cyc();
    chk("no_watchdog_stall", {63'd0, bus.StallMul}, 64'd1);
    chk("no_watchdog_err", {63'd0, bus.TimeoutErr}, 64'd0);
`endif
    chk("run_stall", {63'd0, bus.StallMul}, 64'd1);

    rst_n     = 1'b0;
    bus.MfhiE = 1'b1;
    #1;
    chk("midrun_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("midrun_stall", {63'd0, bus.StallMul}, 64'd0);
    chk("midrun_mulrst", {63'd0, bus.MulRst}, 64'd1);
    chk("midrun_start", {63'd0, bus.MulStartE}, 64'd0);
    chk("midrun_read", {32'd0, bus.HiLoOutE}, 64'd0);
    chk("midrun_err", {63'd0, bus.TimeoutErr}, 64'd0);
    bus.MfhiE = 1'b0;
    bus.MultE = 1'b0;
    hang      = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    mfhi(32'd0);
    mflo(32'd0);

    repeat (3) cyc();
    chk("mul_q_empty", 64'(mul_q.size()), 64'd0);
    chk("rd_q_empty", 64'(rd_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
